decomp_fetch_seq: RTL

- Sequencing controller for the instruction decompressor, sitting between CPU fetch and the decompressor's instruction memory and token table.
- Accepts CPU fetch requests and tracks a compressed-space PC separately from the CPU PC.
- Expands each token instruction into 1..4 table entries, one per CPU fetch, and redirects on branches.
- Arbitrates the single token-table port between expansion reads and the table loader's writes.

---
 rtl/decomp_fetch_seq.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/decomp_fetch_seq.sv
// Fetch sequencer for the instruction decompressor: tracks the compressed PC, expands token
// instructions into table entries one CPU fetch at a time, and shares the table port with loads.
module decomp_fetch_seq #(
  parameter int unsigned           WIDTH      = 32,
  parameter int unsigned           ENC_LEN    = 4,
  parameter logic [ENC_LEN-1:0]    OPCODE     = 4'b1111,
  parameter logic [WIDTH-1:0]      PCADD      = 32'd4,
  parameter int unsigned           TBL_AW     = 7,
  parameter int unsigned           STARVE_LIM = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fetch_req,
  input  logic [WIDTH-1:0]  pc_cpu,
  output logic [WIDTH-1:0]  instr_out,
  output logic              instr_valid,
  output logic              mem_rd,
  output logic [WIDTH-1:0]  mem_addr,
  input  logic              mem_valid,
  input  logic [WIDTH-1:0]  mem_data,
  output logic              tbl_rd,
  output logic              tbl_we,
  output logic [TBL_AW-1:0] tbl_addr,
  output logic [WIDTH-1:0]  tbl_wdata,
  input  logic [WIDTH-1:0]  tbl_data,
  input  logic              wr_req,
  input  logic [TBL_AW-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  output logic              wr_ack,
  output logic              expanding
);

  localparam int unsigned SW = (STARVE_LIM < 1) ? 1 : $clog2(STARVE_LIM + 1);

  typedef enum logic [1:0] {StIdle, StMemWait, StTblWait, StExpHold} state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   cpc_q, cpc_d;
  logic [WIDTH-1:0]   exp_pc_q, exp_pc_d;
  logic [TBL_AW-1:0]  tok_base_q, tok_base_d;
  logic [1:0]         idx_q, idx_d;
  logic [1:0]         rem_q, rem_d;
  logic [SW-1:0]      starve_q, starve_d;
  logic [WIDTH-1:0]   instr_out_q, instr_out_d;
  logic               instr_valid_q, instr_valid_d;
  logic               exp_q, exp_d;
  logic               wr_ack_q;
  logic               wr_arm_q, wr_arm_d;
  logic [WIDTH-1:0]   tbl_wdata_q;

  logic               seq, req, starved, wr_win, blocked;
  logic               mem_is_tok;
  logic [1:0]         mem_cnt1;
  logic [TBL_AW-1:0]  mem_base;

  assign seq        = (pc_cpu == exp_pc_q);
  // The delivery cycle still has the old request on the bus; it must not be re-accepted.
  assign req        = fetch_req & ~instr_valid_q & ~reset;
  assign starved    = (starve_q >= SW'(STARVE_LIM));
  // A write is only granted once its data has been captured into tbl_wdata_q.
  assign wr_win     = wr_arm_q & wr_req & (~fetch_req | starved);
  assign mem_is_tok = (mem_data[WIDTH-1 -: ENC_LEN] == OPCODE);
  assign mem_cnt1   = mem_data[WIDTH-ENC_LEN-1 -: 2];
  assign mem_base   = mem_data[TBL_AW-1:0];

  always_comb begin
    state_d       = state_q;
    cpc_d         = cpc_q;
    exp_pc_d      = exp_pc_q;
    tok_base_d    = tok_base_q;
    idx_d         = idx_q;
    rem_d         = rem_q;
    instr_out_d   = instr_out_q;
    instr_valid_d = 1'b0;
    exp_d         = exp_q;
    mem_rd        = 1'b0;
    mem_addr      = '0;
    tbl_rd        = 1'b0;
    tbl_we        = 1'b0;
    tbl_addr      = '0;

    unique case (state_q)
      StIdle: begin
        // Held through the final entry's delivery cycle, dropped after it.
        exp_d = 1'b0;
        if (wr_win) begin
          tbl_we   = 1'b1;
          tbl_addr = wr_addr;
        end else if (req) begin
          mem_rd   = 1'b1;
          mem_addr = seq ? cpc_q : pc_cpu;
          if (!seq) cpc_d = pc_cpu;
          exp_pc_d = pc_cpu + PCADD;
          state_d  = StMemWait;
        end
      end
      StMemWait: begin
        if (mem_valid) begin
          if (mem_is_tok) begin
            tbl_rd     = 1'b1;
            tbl_addr   = mem_base;
            tok_base_d = mem_base;
            idx_d      = 2'd1;
            rem_d      = mem_cnt1;
            exp_d      = 1'b1;
            state_d    = StTblWait;
          end else begin
            instr_out_d   = mem_data;
            instr_valid_d = 1'b1;
            cpc_d         = cpc_q + PCADD;
            state_d       = StIdle;
          end
        end
      end
      StTblWait: begin
        instr_out_d   = tbl_data;
        instr_valid_d = 1'b1;
        if (rem_q == 2'd0) begin
          cpc_d   = cpc_q + PCADD;
          state_d = StIdle;
        end else begin
          state_d = StExpHold;
        end
      end
      StExpHold: begin
        if (wr_win) begin
          tbl_we   = 1'b1;
          tbl_addr = wr_addr;
        end else if (req && seq) begin
          tbl_rd   = 1'b1;
          tbl_addr = tok_base_q + TBL_AW'(idx_q);
          idx_d    = idx_q + 2'd1;
          rem_d    = rem_q - 2'd1;
          exp_pc_d = pc_cpu + PCADD;
          state_d  = StTblWait;
        end else if (req) begin
          // Branch out of the token: abandon the remaining entries.
          exp_d    = 1'b0;
          cpc_d    = pc_cpu;
          mem_rd   = 1'b1;
          mem_addr = pc_cpu;
          exp_pc_d = pc_cpu + PCADD;
          state_d  = StMemWait;
        end
      end
    endcase
  end

  always_comb begin
    blocked  = wr_req & fetch_req & ~tbl_we & ~wr_ack_q;
    wr_arm_d = wr_req & ~tbl_we & ~wr_ack_q;
    starve_d = starve_q;
    if (wr_ack_q) begin
      starve_d = '0;
    end else if (blocked && !starved) begin
      starve_d = starve_q + SW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= StIdle;
      cpc_q         <= '0;
      exp_pc_q      <= '0;
      tok_base_q    <= '0;
      idx_q         <= '0;
      rem_q         <= '0;
      starve_q      <= '0;
      instr_out_q   <= '0;
      instr_valid_q <= 1'b0;
      exp_q         <= 1'b0;
      wr_ack_q      <= 1'b0;
      wr_arm_q      <= 1'b0;
      tbl_wdata_q   <= '0;
    end else begin
      state_q       <= state_d;
      cpc_q         <= cpc_d;
      exp_pc_q      <= exp_pc_d;
      tok_base_q    <= tok_base_d;
      idx_q         <= idx_d;
      rem_q         <= rem_d;
      starve_q      <= starve_d;
      instr_out_q   <= instr_out_d;
      instr_valid_q <= instr_valid_d;
      exp_q         <= exp_d;
      wr_ack_q      <= tbl_we;
      wr_arm_q      <= wr_arm_d;
      if (wr_req && !tbl_we && !wr_ack_q) tbl_wdata_q <= wr_data;
    end
  end

  assign instr_out   = instr_out_q;
  assign instr_valid = instr_valid_q;
  assign wr_ack      = wr_ack_q;
  assign expanding   = exp_q;
  assign tbl_wdata   = tbl_wdata_q;

endmodule
